// File: rtl/tx_vc_router.sv
// tx_vc_router: transmit-side router built from three show-ahead FIFO stages.
//   main FIFO -> NUM_VC virtual-channel FIFOs (steered by VC-ID field)
//             -> NUM_DEST destination FIFOs (steered by destination field)
//             -> registered per-destination read port.
// Optional feature macro: TX_VC_ROUTER_RR_EN
//   defined   : per-destination round-robin arbitration among VCs
//   undefined : fixed priority, lowest-numbered eligible VC wins
// Ports:
//   clk        clock, all state on rising edge
//   RESET_L    synchronous active-low reset
//   PUSH_MAIN  write DATA_IN into main FIFO
//   DATA_IN    ingress word {vc_id, dest, payload}
//   vc_high    VC pause threshold
//   d_high     destination pause threshold
//   POP_D      per-destination read strobe
//   DATA_OUT   registered read data, destination i at slice i
//   VALID_OUT  DATA_OUT slice i valid
//   MAIN_FULL  main FIFO full
//   PAUSE_VC   VC occupancy >= vc_high
//   PAUSE_D    destination occupancy >= d_high
//   ERROR      sticky {dest underflow[NUM_DEST-1:0], VC overflow, main overflow}
//   IDLE       all FIFOs empty
module tx_vc_router #(
    parameter int unsigned DATA_WIDTH = 6,
    parameter int unsigned NUM_VC     = 2,
    parameter int unsigned NUM_DEST   = 2,
    parameter int unsigned MAIN_DEPTH = 4,
    parameter int unsigned VC_DEPTH   = 16,
    parameter int unsigned D_DEPTH    = 4
) (
    input  logic                           clk,
    input  logic                           RESET_L,
    input  logic                           PUSH_MAIN,
    input  logic [DATA_WIDTH-1:0]          DATA_IN,
    input  logic [$clog2(VC_DEPTH):0]      vc_high,
    input  logic [$clog2(D_DEPTH):0]       d_high,
    input  logic [NUM_DEST-1:0]            POP_D,
    output logic [NUM_DEST*DATA_WIDTH-1:0] DATA_OUT,
    output logic [NUM_DEST-1:0]            VALID_OUT,
    output logic                           MAIN_FULL,
    output logic [NUM_VC-1:0]              PAUSE_VC,
    output logic [NUM_DEST-1:0]            PAUSE_D,
    output logic [NUM_DEST+1:0]            ERROR,
    output logic                           IDLE
);
    localparam int unsigned VCW = $clog2(NUM_VC);
    localparam int unsigned DW  = $clog2(NUM_DEST);
    localparam int unsigned MPW = $clog2(MAIN_DEPTH);
    localparam int unsigned VPW = $clog2(VC_DEPTH);
    localparam int unsigned DPW = $clog2(D_DEPTH);

    localparam logic [MPW:0] MainFullCnt = (MPW+1)'(MAIN_DEPTH);
    localparam logic [VPW:0] VcFullCnt   = (VPW+1)'(VC_DEPTH);
    localparam logic [DPW:0] DFullCnt    = (DPW+1)'(D_DEPTH);

    // main FIFO
    logic [DATA_WIDTH-1:0] main_mem [MAIN_DEPTH];
    logic [MPW-1:0]        main_rd_q, main_wr_q;
    logic [MPW:0]          main_cnt_q;
    logic [DATA_WIDTH-1:0] main_head;
    logic [VCW-1:0]        main_head_vc;
    logic                  main_pop, main_push, main_ovf;

    // VC FIFOs
    logic [DATA_WIDTH-1:0] vc_mem [NUM_VC][VC_DEPTH];
    logic [VPW-1:0]        vc_rd_q [NUM_VC];
    logic [VPW-1:0]        vc_wr_q [NUM_VC];
    logic [VPW:0]          vc_cnt_q [NUM_VC];
    logic [DATA_WIDTH-1:0] vc_head [NUM_VC];
    logic [DW-1:0]         vc_dest [NUM_VC];
    logic [NUM_VC-1:0]     vc_elig, vc_pop, vc_push;
    logic                  vc_ovf;

    // destination FIFOs
    logic [DATA_WIDTH-1:0] d_mem [NUM_DEST][D_DEPTH];
    logic [DPW-1:0]        d_rd_q [NUM_DEST];
    logic [DPW-1:0]        d_wr_q [NUM_DEST];
    logic [DPW:0]          d_cnt_q [NUM_DEST];
    logic [NUM_DEST-1:0]   d_push, d_pop, d_udf;
    logic [VCW-1:0]        d_sel [NUM_DEST];
    logic [VCW-1:0]        cand;

`ifdef TX_VC_ROUTER_RR_EN
    logic [VCW-1:0]        rr_q [NUM_DEST];
`endif

    logic [NUM_DEST*DATA_WIDTH-1:0] data_out_q;
    logic [NUM_DEST-1:0]            valid_q;
    logic [NUM_DEST+1:0]            err_q;

    assign DATA_OUT  = data_out_q;
    assign VALID_OUT = valid_q;
    assign ERROR     = err_q;

    // status, combinational from counters and live thresholds
    always_comb begin
        MAIN_FULL = (main_cnt_q == MainFullCnt);
        IDLE      = (main_cnt_q == '0);
        PAUSE_VC  = '0;
        PAUSE_D   = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            PAUSE_VC[v] = (vc_cnt_q[v] >= vc_high);
            if (vc_cnt_q[v] != '0) IDLE = 1'b0;
        end
        for (int d = 0; d < NUM_DEST; d++) begin
            PAUSE_D[d] = (d_cnt_q[d] >= d_high);
            if (d_cnt_q[d] != '0) IDLE = 1'b0;
        end
    end

    // stage 2: VC heads -> destination FIFOs, one arbiter per destination
    always_comb begin
        d_push = '0;
        vc_pop = '0;
        cand   = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            vc_head[v] = vc_mem[v][vc_rd_q[v]];
            vc_dest[v] = vc_head[v][DATA_WIDTH-1-VCW -: DW];
            // full check covers d_high > D_DEPTH, where pause alone never stops writes
            vc_elig[v] = (vc_cnt_q[v] != '0) && !PAUSE_D[vc_dest[v]] &&
                         (d_cnt_q[vc_dest[v]] != DFullCnt);
        end
        for (int d = 0; d < NUM_DEST; d++) begin
            d_sel[d] = '0;
            for (int k = 0; k < NUM_VC; k++) begin
`ifdef TX_VC_ROUTER_RR_EN
                cand = rr_q[d] + VCW'(k);
`else
                cand = VCW'(k);
`endif
                if (!d_push[d] && vc_elig[cand] && (vc_dest[cand] == DW'(d))) begin
                    d_push[d] = 1'b1;
                    d_sel[d]  = cand;
                end
            end
        end
        for (int d = 0; d < NUM_DEST; d++) begin
            if (d_push[d]) vc_pop[d_sel[d]] = 1'b1;
        end
    end

    // stage 1: main head -> VC FIFO; stage 3 read qualification
    always_comb begin
        main_head    = main_mem[main_rd_q];
        main_head_vc = main_head[DATA_WIDTH-1 -: VCW];
        main_pop     = (main_cnt_q != '0) && !PAUSE_VC[main_head_vc];
        main_push    = PUSH_MAIN && (!MAIN_FULL || main_pop);
        main_ovf     = PUSH_MAIN && MAIN_FULL && !main_pop;
        vc_push      = '0;
        vc_ovf       = 1'b0;
        if (main_pop) begin
            if ((vc_cnt_q[main_head_vc] == VcFullCnt) && !vc_pop[main_head_vc]) begin
                vc_ovf = 1'b1;
            end else begin
                vc_push[main_head_vc] = 1'b1;
            end
        end
        for (int d = 0; d < NUM_DEST; d++) begin
            d_pop[d] = POP_D[d] && (d_cnt_q[d] != '0);
            d_udf[d] = POP_D[d] && (d_cnt_q[d] == '0);
        end
    end

    // storage arrays carry no reset; counters define what is live
    always_ff @(posedge clk) begin
        if (main_push) main_mem[main_wr_q] <= DATA_IN;
        for (int v = 0; v < NUM_VC; v++) begin
            if (vc_push[v]) vc_mem[v][vc_wr_q[v]] <= main_head;
        end
        for (int d = 0; d < NUM_DEST; d++) begin
            if (d_push[d]) d_mem[d][d_wr_q[d]] <= vc_head[d_sel[d]];
        end
    end

    always_ff @(posedge clk) begin
        if (!RESET_L) begin
            main_rd_q  <= '0;
            main_wr_q  <= '0;
            main_cnt_q <= '0;
            for (int v = 0; v < NUM_VC; v++) begin
                vc_rd_q[v]  <= '0;
                vc_wr_q[v]  <= '0;
                vc_cnt_q[v] <= '0;
            end
            for (int d = 0; d < NUM_DEST; d++) begin
                d_rd_q[d]  <= '0;
                d_wr_q[d]  <= '0;
                d_cnt_q[d] <= '0;
`ifdef TX_VC_ROUTER_RR_EN
                rr_q[d]    <= '0;
`endif
            end
            data_out_q <= '0;
            valid_q    <= '0;
            err_q      <= '0;
        end else begin
            if (main_push) main_wr_q <= main_wr_q + MPW'(1);
            if (main_pop)  main_rd_q <= main_rd_q + MPW'(1);
            if (main_push && !main_pop)      main_cnt_q <= main_cnt_q + (MPW+1)'(1);
            else if (!main_push && main_pop) main_cnt_q <= main_cnt_q - (MPW+1)'(1);

            for (int v = 0; v < NUM_VC; v++) begin
                if (vc_push[v]) vc_wr_q[v] <= vc_wr_q[v] + VPW'(1);
                if (vc_pop[v])  vc_rd_q[v] <= vc_rd_q[v] + VPW'(1);
                if (vc_push[v] && !vc_pop[v])      vc_cnt_q[v] <= vc_cnt_q[v] + (VPW+1)'(1);
                else if (!vc_push[v] && vc_pop[v]) vc_cnt_q[v] <= vc_cnt_q[v] - (VPW+1)'(1);
            end

            for (int d = 0; d < NUM_DEST; d++) begin
                if (d_push[d]) d_wr_q[d] <= d_wr_q[d] + DPW'(1);
                if (d_pop[d])  d_rd_q[d] <= d_rd_q[d] + DPW'(1);
                if (d_push[d] && !d_pop[d])      d_cnt_q[d] <= d_cnt_q[d] + (DPW+1)'(1);
                else if (!d_push[d] && d_pop[d]) d_cnt_q[d] <= d_cnt_q[d] - (DPW+1)'(1);
                if (d_pop[d]) data_out_q[d*DATA_WIDTH +: DATA_WIDTH] <= d_mem[d][d_rd_q[d]];
`ifdef TX_VC_ROUTER_RR_EN
                if (d_push[d]) rr_q[d] <= d_sel[d] + VCW'(1);
`endif
            end

            valid_q <= d_pop;
            err_q   <= err_q | {d_udf, vc_ovf, main_ovf};
        end
    end

endmodule

// File: tb/tb_tx_vc_router.sv
module tb_tx_vc_router;
    localparam int WD = 6;
    localparam int NV = 2;
    localparam int ND = 2;
    localparam int MD = 4;
    localparam int VD = 16;
    localparam int DD = 4;

    logic              clk = 1'b0;
    logic              RESET_L;
    logic              PUSH_MAIN;
    logic [WD-1:0]     DATA_IN;
    logic [4:0]        vc_high;
    logic [2:0]        d_high;
    logic [ND-1:0]     POP_D;
    logic [ND*WD-1:0]  DATA_OUT;
    logic [ND-1:0]     VALID_OUT;
    logic              MAIN_FULL;
    logic [NV-1:0]     PAUSE_VC;
    logic [ND-1:0]     PAUSE_D;
    logic [ND+1:0]     ERROR;
    logic              IDLE;

    tx_vc_router dut (
        .clk      (clk),
        .RESET_L  (RESET_L),
        .PUSH_MAIN(PUSH_MAIN),
        .DATA_IN  (DATA_IN),
        .vc_high  (vc_high),
        .d_high   (d_high),
        .POP_D    (POP_D),
        .DATA_OUT (DATA_OUT),
        .VALID_OUT(VALID_OUT),
        .MAIN_FULL(MAIN_FULL),
        .PAUSE_VC (PAUSE_VC),
        .PAUSE_D  (PAUSE_D),
        .ERROR    (ERROR),
        .IDLE     (IDLE)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Reference model: plain queues, every decision taken on pre-edge occupancy.
    logic [WD-1:0] mq[$];
    logic [WD-1:0] vq[NV][$];
    logic [WD-1:0] dq[ND][$];
    int            rr[ND];
    logic [WD-1:0] mout[ND];
    logic [ND-1:0] mvalid;
    logic [ND+1:0] merr;

    function automatic int vc_of(input logic [WD-1:0] w);
        return int'(w[WD-1]);
    endfunction

    function automatic int dest_of(input logic [WD-1:0] w);
        return int'(w[WD-2]);
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int v = 0; v < NV; v++) vq[v].delete();
        for (int d = 0; d < ND; d++) begin
            dq[d].delete();
            rr[d]   = 0;
            mout[d] = '0;
        end
        mvalid = '0;
        merr   = '0;
    endtask

    task automatic model_step();
        int  vsz[NV];
        int  dsz[ND];
        int  msz;
        bit  dwr[ND];
        int  dsel[ND];
        bit  vpopped[NV];
        bit  mpop;
        int  v;
        logic [WD-1:0] w;
        if (!RESET_L) begin
            model_reset();
            return;
        end
        msz = mq.size();
        for (int i = 0; i < NV; i++) begin
            vsz[i]     = vq[i].size();
            vpopped[i] = 0;
        end
        for (int i = 0; i < ND; i++) dsz[i] = dq[i].size();
        // destination arbitration
        for (int d = 0; d < ND; d++) begin
            dwr[d]  = 0;
            dsel[d] = 0;
            for (int k = 0; k < NV; k++) begin
`ifdef TX_VC_ROUTER_RR_EN
                v = (rr[d] + k) % NV;
`else
                v = k;
`endif
                if (!dwr[d] && vsz[v] > 0 && dest_of(vq[v][0]) == d &&
                    dsz[d] < int'(d_high) && dsz[d] < DD) begin
                    dwr[d]  = 1;
                    dsel[d] = v;
                end
            end
        end
        mpop = (msz > 0) && (vsz[vc_of(mq[0])] < int'(vc_high));
        // output stage
        for (int d = 0; d < ND; d++) begin
            mvalid[d] = 1'b0;
            if (POP_D[d]) begin
                if (dsz[d] > 0) begin
                    mout[d]   = dq[d].pop_front();
                    mvalid[d] = 1'b1;
                end else begin
                    merr[2+d] = 1'b1;
                end
            end
        end
        for (int d = 0; d < ND; d++) begin
            if (dwr[d]) begin
                w = vq[dsel[d]].pop_front();
                dq[d].push_back(w);
                vpopped[dsel[d]] = 1;
                rr[d] = (dsel[d] + 1) % NV;
            end
        end
        if (mpop) begin
            w = mq.pop_front();
            v = vc_of(w);
            if (vsz[v] == VD && !vpopped[v]) merr[1] = 1'b1;
            else vq[v].push_back(w);
        end
        if (PUSH_MAIN) begin
            if (msz == MD && !mpop) merr[0] = 1'b1;
            else mq.push_back(DATA_IN);
        end
    endtask

    task automatic check_outputs();
        logic [NV-1:0] pv;
        logic [ND-1:0] pd;
        bit            idle;
        idle = (mq.size() == 0);
        for (int v = 0; v < NV; v++) begin
            pv[v] = (vq[v].size() >= int'(vc_high));
            if (vq[v].size() != 0) idle = 0;
        end
        for (int d = 0; d < ND; d++) begin
            pd[d] = (dq[d].size() >= int'(d_high));
            if (dq[d].size() != 0) idle = 0;
            check_eq($sformatf("data_out[%0d]", d), 64'(DATA_OUT[d*WD +: WD]), 64'(mout[d]));
        end
        check_eq("valid_out", 64'(VALID_OUT), 64'(mvalid));
        check_eq("error", 64'(ERROR), 64'(merr));
        check_eq("pause_vc", 64'(PAUSE_VC), 64'(pv));
        check_eq("pause_d", 64'(PAUSE_D), 64'(pd));
        check_eq("main_full", 64'(MAIN_FULL), 64'(mq.size() == MD));
        check_eq("idle", 64'(IDLE), 64'(idle));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_ticks(input int n);
        PUSH_MAIN = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push_word(input logic [WD-1:0] w);
        PUSH_MAIN = 1'b1;
        DATA_IN   = w;
        tick();
        PUSH_MAIN = 1'b0;
    endtask

    task automatic do_reset();
        RESET_L   = 1'b0;
        PUSH_MAIN = 1'b0;
        tick();
        RESET_L = 1'b1;
    endtask

    // word = {vc, dest, payload[3:0]}
    function automatic logic [WD-1:0] mk(input int vc, input int dest);
        logic [3:0] p;
        p = 4'($urandom);
        return {1'(vc), 1'(dest), p};
    endfunction

    initial begin
        model_reset();
        RESET_L   = 1'b0;
        PUSH_MAIN = 1'b0;
        DATA_IN   = '0;
        vc_high   = 5'd16;
        d_high    = 3'd4;
        POP_D     = '0;
        @(negedge clk);
        tick();
        tick();
        RESET_L = 1'b1;

        // single word end to end, popped as soon as it lands
        POP_D = 2'b01;
        push_word(6'h05);
        idle_ticks(5);
        POP_D = '0;

        // main overflow with the VC stage stalled
        do_reset();
        vc_high = 5'd0;
        for (int i = 0; i < 5; i++) push_word(mk(i % 2, 0));
        idle_ticks(2);
        vc_high = 5'd16;
        POP_D   = 2'b11;
        idle_ticks(12);
        POP_D   = '0;

        // per-channel pause thresholds
        do_reset();
        vc_high = 5'd2;
        d_high  = 3'd1;
        for (int i = 0; i < 6; i++) push_word(mk(i % 2, 0));
        idle_ticks(8);

        // arbitration order: four words queued in each VC, all for destination 0
        do_reset();
        vc_high = 5'd16;
        d_high  = 3'd0;
        for (int i = 0; i < 4; i++) push_word(mk(0, 0));
        for (int i = 0; i < 4; i++) push_word(mk(1, 0));
        idle_ticks(4);
        d_high = 3'd4;
        POP_D  = 2'b01;
        idle_ticks(16);
        POP_D  = '0;

        // two independent streams, both destinations busy every cycle
        do_reset();
        POP_D = 2'b11;
        for (int i = 0; i < 20; i++) push_word(mk(i % 2, i % 2));
        idle_ticks(6);

        // underflow, then reset in the middle of traffic
        do_reset();
        POP_D = 2'b10;
        tick();
        POP_D = '0;
        for (int i = 0; i < 6; i++) push_word(mk(i % 2, (i / 2) % 2));
        POP_D = 2'b11;
        tick();
        do_reset();
        idle_ticks(2);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                vc_high = 5'($urandom_range(1, 16));
                d_high  = 3'($urandom_range(1, 4));
            end
            RESET_L   = ($urandom_range(0, 299) != 0);
            PUSH_MAIN = ($urandom_range(0, 2) != 0);
            DATA_IN   = 6'($urandom);
            POP_D     = 2'($urandom);
            tick();
        end
        RESET_L   = 1'b1;
        PUSH_MAIN = 1'b0;
        POP_D     = 2'b11;
        vc_high   = 5'd16;
        d_high    = 3'd4;
        idle_ticks(40);
        check_eq("drained_idle", 64'(IDLE), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout cycle=%0d got=running expected=finished", cyc);
        $fatal(1, "timeout");
    end

endmodule
